maze_move_controller: RTL and testbench

//  Sequences player movement and viewport scrolling for the maze display. Takes button presses,

---
 rtl/maze_move_controller.sv | 179 +++++++++++++++++
 tb/tb_maze_move_controller.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/maze_move_controller.sv
// rtl/maze_move_controller.sv - frame-synchronous player move and viewport controller (optional MAZE_AUTOREPEAT_EN)
module maze_move_controller #(
  parameter int START_X       = 0,
  parameter int START_Y       = 0,
  parameter int REPEAT_FRAMES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         btn_up,
  input  logic         btn_down,
  input  logic         btn_left,
  input  logic         btn_right,
  input  logic         frame_start,
  input  logic [255:0] path_data,
  input  logic [4:0]   maze_width,
  input  logic [4:0]   maze_height,
  input  logic [4:0]   tile_width,
  input  logic [4:0]   tile_height,
  output logic [6:0]   char_x,
  output logic [6:0]   char_y,
  output logic [4:0]   x_coord,
  output logic [4:0]   y_coord,
  output logic         move_done,
  output logic         move_reject,
  output logic [15:0]  move_count
);

  typedef enum logic [1:0] {IDLE, CHECK, WAIT_FRAME, COMMIT} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  state_t state, next_state;
  dir_t   dir_q, req_dir;

  // Button bit order doubles as the arbitration order: up wins over down, left, right.
  logic [3:0] btn_now, btn_prev, edges, req_src;
  logic       req_any;
  logic [6:0] tgt_x, tgt_y;
  logic       out_of_range, blocked;

  assign btn_now = {btn_up, btn_down, btn_left, btn_right};
  assign edges   = btn_now & ~btn_prev;

  // Previous-level register for rising-edge detection.
  always_ff @(posedge clk) begin
    if (reset) btn_prev <= 4'd0;
    else       btn_prev <= btn_now;
  end

`ifdef MAZE_AUTOREPEAT_EN
  // Frames seen in IDLE since the last commit/request while a button stays held.
  logic [15:0] rep_cnt;
  logic        rep_fire;

  assign rep_fire = (rep_cnt >= 16'(REPEAT_FRAMES - 1)) && (|btn_now) && !(|edges);
  assign req_src  = (|edges) ? edges : (rep_fire ? btn_now : 4'd0);

  // Repeat frame counter; cleared by any edge, release, accepted request or commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt <= 16'd0;
    end else if ((|edges) || !(|btn_now) || state == COMMIT || (state == IDLE && req_any)) begin
      rep_cnt <= 16'd0;
    end else if (state == IDLE && frame_start && rep_cnt != 16'hFFFF) begin
      rep_cnt <= rep_cnt + 16'd1;
    end
  end
`else
  assign req_src = edges;
`endif

  // Fixed-priority pick of one direction among simultaneous requests.
  always_comb begin
    req_any = |req_src;
    req_dir = DIR_RIGHT;
    if (req_src[3])      req_dir = DIR_UP;
    else if (req_src[2]) req_dir = DIR_DOWN;
    else if (req_src[1]) req_dir = DIR_LEFT;
  end

  // Target tile for the stored direction and its legality.
  always_comb begin
    tgt_x        = char_x;
    tgt_y        = char_y;
    out_of_range = 1'b0;
    case (dir_q)
      DIR_UP: begin
        tgt_y        = char_y - 7'd1;
        out_of_range = (char_y == 7'd0);
      end
      DIR_DOWN: begin
        tgt_y        = char_y + 7'd1;
        out_of_range = (char_y == 7'h7F);
      end
      DIR_LEFT: begin
        tgt_x        = char_x - 7'd1;
        out_of_range = (char_x == 7'd0);
      end
      default: begin
        tgt_x        = char_x + 7'd1;
        out_of_range = (char_x == 7'h7F);
      end
    endcase
    blocked = out_of_range
           || (tgt_x >= {2'b00, maze_width})
           || (tgt_y >= {2'b00, maze_height})
           || !path_data[{tgt_y[3:0], tgt_x[3:0]}];
  end

  // Viewport origin on one axis: zero when the maze fits the screen, else keep the
  // character centred but never scroll past the far maze edge.
  function automatic logic [4:0] viewport(input logic [6:0] c, input logic [4:0] maze,
                                          input logic [4:0] tsh, input logic [9:0] screen);
    logic [14:0] span;
    logic [9:0]  vis, half, lim, off, cw;
    span = 15'(maze) << tsh;
    cw   = 10'(c);
    vis  = screen >> tsh;
    half = vis >> 1;
    lim  = 10'(maze) - vis;
    off  = cw - half;
    if (span <= 15'(screen))  viewport = 5'd0;
    else if (cw < half)       viewport = 5'd0;
    else if (off < lim)       viewport = off[4:0];
    else                      viewport = lim[4:0];
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic; disabling always parks the FSM in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:       if (req_any) next_state = CHECK;
      CHECK:      next_state = blocked ? IDLE : WAIT_FRAME;
      WAIT_FRAME: if (frame_start) next_state = COMMIT;
      default:    next_state = IDLE;
    endcase
    if (!enable) next_state = IDLE;
  end

  // Latch the winning direction when a request is accepted.
  always_ff @(posedge clk) begin
    if (reset)                    dir_q <= DIR_UP;
    else if (state == IDLE && req_any) dir_q <= req_dir;
  end

  // Committed position, viewport, counter and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      char_x      <= 7'(START_X);
      char_y      <= 7'(START_Y);
      x_coord     <= 5'd0;
      y_coord     <= 5'd0;
      move_count  <= 16'd0;
      move_done   <= 1'b0;
      move_reject <= 1'b0;
    end else begin
      move_done   <= 1'b0;
      move_reject <= 1'b0;
      if (enable) begin
        if (state == CHECK && blocked) move_reject <= 1'b1;
        if (state == COMMIT) begin
          char_x    <= tgt_x;
          char_y    <= tgt_y;
          x_coord   <= viewport(tgt_x, maze_width, tile_width, 10'd640);
          y_coord   <= viewport(tgt_y, maze_height, tile_height, 10'd480);
          move_done <= 1'b1;
          if (move_count != 16'hFFFF) move_count <= move_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_maze_move_controller.sv
// tb/tb_maze_move_controller.sv - self-checking bench for maze_move_controller
module tb_maze_move_controller;

  logic         clk = 1'b0;
  logic         reset, enable;
  logic         btn_up, btn_down, btn_left, btn_right, frame_start;
  logic [255:0] path_data;
  logic [4:0]   maze_width, maze_height, tile_width, tile_height;
  logic [6:0]   char_x, char_y;
  logic [4:0]   x_coord, y_coord;
  logic         move_done, move_reject;
  logic [15:0]  move_count;

  always #5 clk = ~clk;

  maze_move_controller #(.START_X(1), .START_Y(1)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
    .frame_start(frame_start), .path_data(path_data),
    .maze_width(maze_width), .maze_height(maze_height),
    .tile_width(tile_width), .tile_height(tile_height),
    .char_x(char_x), .char_y(char_y), .x_coord(x_coord), .y_coord(y_coord),
    .move_done(move_done), .move_reject(move_reject), .move_count(move_count)
  );

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int rej_seen = 0;

  // reference model state
  int mx, my, mxc, myc, mcnt;
  int mw, mh, tw, th;
  bit path [256];

  always @(posedge clk) begin
    if (move_done)   done_seen++;
    if (move_reject) rej_seen++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int vp_ref(input int c, input int m, input int t, input int scr);
    int vis, half, v;
    if (m * (1 << t) <= scr) return 0;
    vis  = scr / (1 << t);
    half = vis / 2;
    if (c < half) return 0;
    v = c - half;
    if (v > m - vis) v = m - vis;
    return v;
  endfunction

  function automatic void model_eval(input logic [3:0] mask, output bit blk,
                                     output int tx, output int ty);
    tx = mx; ty = my;
    if (mask[3])      ty = my - 1;
    else if (mask[2]) ty = my + 1;
    else if (mask[1]) tx = mx - 1;
    else              tx = mx + 1;
    if (tx < 0 || ty < 0 || tx >= mw || ty >= mh) blk = 1'b1;
    else blk = !path[tx + 16 * ty];
  endfunction

  task automatic model_commit(input int tx, input int ty);
    mx = tx; my = ty;
    if (mcnt < 65535) mcnt++;
    mxc = vp_ref(mx, mw, tw, 640);
    myc = vp_ref(my, mh, th, 480);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_char_x"}, int'(char_x), mx);
    check({tag, "_char_y"}, int'(char_y), my);
    check({tag, "_x_coord"}, int'(x_coord), mxc);
    check({tag, "_y_coord"}, int'(y_coord), myc);
    check({tag, "_count"}, int'(move_count), mcnt);
  endtask

  task automatic apply_dims(input int w, input int h, input int t_w, input int t_h);
    @(negedge clk);
    mw = w; mh = h; tw = t_w; th = t_h;
    maze_width  = 5'(w);
    maze_height = 5'(h);
    tile_width  = 5'(t_w);
    tile_height = 5'(t_h);
    for (int k = 0; k < 256; k++) path_data[k] = path[k];
  endtask

  task automatic set_btn(input logic [3:0] mask);
    {btn_up, btn_down, btn_left, btn_right} = mask;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic do_move(input string tag, input logic [3:0] mask, input int gap);
    int d0, r0, tx, ty;
    bit blk;
    model_eval(mask, blk, tx, ty);
    d0 = done_seen; r0 = rej_seen;
    @(negedge clk); set_btn(mask);
    @(negedge clk); set_btn(4'd0);
    repeat (gap) @(negedge clk);
    pulse_frame();
    repeat (4) @(negedge clk);
    if (!blk) model_commit(tx, ty);
    check({tag, "_done"}, done_seen - d0, blk ? 0 : 1);
    check({tag, "_reject"}, rej_seen - r0, blk ? 1 : 0);
    check_state(tag);
  endtask

  initial begin
    int d0, r0, tx, ty;
    bit blk;
    reset = 1'b1; enable = 1'b1; frame_start = 1'b0;
    set_btn(4'd0);
    for (int k = 0; k < 256; k++) path[k] = 1'b0;
    for (int x = 0; x < 4; x++) path[x + 16] = 1'b1;
    path[2] = 1'b1;
    apply_dims(4, 4, 2, 2);
    mx = 1; my = 1; mxc = 0; myc = 0; mcnt = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state and quiet period
    @(negedge clk);
    check_state("reset");
    check("reset_done_lvl", int'(move_done), 0);
    check("reset_reject_lvl", int'(move_reject), 0);
    repeat (100) @(negedge clk);
    check("idle_done_pulses", done_seen, 0);
    check("idle_reject_pulses", rej_seen, 0);

    // wall above start
    do_move("wall_up", 4'b1000, 2);

    // right with frame 20 cycles later, latency checked cycle by cycle
    model_eval(4'b0001, blk, tx, ty);
    d0 = done_seen;
    @(negedge clk); set_btn(4'b0001);
    @(negedge clk); set_btn(4'd0);
    repeat (19) @(negedge clk);
    pulse_frame();
    check("lat_commit_cycle_x", int'(char_x), 1);
    @(negedge clk);
    check("lat_out_x", int'(char_x), 2);
    check("lat_done_lvl", int'(move_done), 1);
    repeat (3) @(negedge clk);
    model_commit(tx, ty);
    check("lat_done_cnt", done_seen - d0, 1);
    check_state("lat");

    do_move("upright", 4'b1001, 1);
    do_move("down", 4'b0100, 3);
    do_move("left1", 4'b0010, 1);
    do_move("left2", 4'b0010, 2);
    do_move("left_edge", 4'b0010, 1);
    do_move("right1", 4'b0001, 1);
    do_move("right2", 4'b0001, 1);
    do_move("right3", 4'b0001, 1);
    do_move("right_edge", 4'b0001, 1);

    // second edge while waiting for the frame is ignored
    model_eval(4'b0010, blk, tx, ty);
    d0 = done_seen;
    @(negedge clk); set_btn(4'b0010);
    @(negedge clk); set_btn(4'd0);
    repeat (3) @(negedge clk);
    set_btn(4'b0001);
    @(negedge clk); set_btn(4'd0);
    repeat (2) @(negedge clk);
    pulse_frame();
    repeat (6) @(negedge clk);
    model_commit(tx, ty);
    check("wait_edge_done", done_seen - d0, 1);
    check_state("wait_edge");

    // disabling mid-move drops the request
    d0 = done_seen; r0 = rej_seen;
    @(negedge clk); set_btn(4'b0010);
    @(negedge clk); set_btn(4'd0);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    pulse_frame();
    repeat (4) @(negedge clk);
    check("disable_done", done_seen - d0, 0);
    check("disable_reject", rej_seen - r0, 0);
    check_state("disable");

    // held button commits a single step
    model_eval(4'b0001, blk, tx, ty);
    d0 = done_seen;
    @(negedge clk); set_btn(4'b0001);
    for (int f = 0; f < 5; f++) begin
      repeat (10) @(negedge clk);
      pulse_frame();
    end
    set_btn(4'd0);
    repeat (4) @(negedge clk);
    model_commit(tx, ty);
    check("held_done", done_seen - d0, 1);
    check_state("held");

    // scrolling viewport on a wide maze
    for (int k = 0; k < 256; k++) path[k] = 1'b1;
    apply_dims(16, 16, 6, 2);
    do_move("vp_to4", 4'b0001, 1);
    do_move("vp_to5", 4'b0001, 1);
    check("vp_at5", int'(x_coord), 0);
    for (int s = 0; s < 10; s++) do_move("vp_walk", 4'b0001, 1);
    check("vp_clamp", int'(x_coord), 6);
    do_move("vp_edge", 4'b0001, 1);

    // randomized moves against the model
    for (int i = 0; i < 80; i++) begin
      if (i % 10 == 0) begin
        for (int k = 0; k < 256; k++) path[k] = ($urandom_range(0, 3) != 0);
        apply_dims($urandom_range(1, 16), $urandom_range(1, 16),
                   $urandom_range(2, 9), $urandom_range(2, 9));
      end
      do_move("rand", 4'($urandom_range(1, 15)), $urandom_range(1, 5));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
